// File: rtl/conv_agu_sched.sv
`default_nettype none
// ============================================================================
// Module  : conv_agu_sched
// Brief   : Tile scheduler - queues conv tile descriptors, broadcasts each one
//           to the AGU groups and collects their done flags.
// Rev     : 1.0  initial release
// ============================================================================
module conv_agu_sched #(
    parameter int GRP_NUM    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [39:0]        desc_data,
    input  logic               abort,
    output logic               agu_start,
    input  logic [GRP_NUM-1:0] agu_done,
    output logic [1:0]         conf_mode,
    output logic [7:0]         conf_idx_cnt,
    output logic [7:0]         conf_trip_cnt,
    output logic               conf_is_new,
    output logic               conf_pad_u,
    output logic               conf_pad_l,
    output logic [5:0]         conf_lim_r,
    output logic [5:0]         conf_lim_d,
    output logic [5:0]         conf_row_cnt,
    output logic               busy,
    output logic               tile_done,
    output logic               layer_done,
    output logic [CNT_W-1:0]   tile_cnt
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [39:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [1:0]         r_state;
    logic [GRP_NUM-1:0] r_mask;
    logic               r_last;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_all_done;
    logic               w_fin;
    logic [1:0]         w_state_nxt;
    logic [AW:0]        w_count_nxt;

    always_comb begin
        w_empty     = (r_count == '0);
        w_push      = desc_valid && desc_ready && !abort;
        w_all_done  = &(r_mask | agu_done);
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_all_done) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_pop       = 1'b0;
            w_state_nxt = S_IDLE;
        end
        w_fin       = (r_state == S_WAIT) && (w_state_nxt == S_FIN);
        w_count_nxt = r_count;
        if (abort) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= desc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mask     <= '0;
            r_last     <= 1'b0;
            desc_ready <= 1'b1;
            busy       <= 1'b0;
            agu_start  <= 1'b0;
            tile_done  <= 1'b0;
            layer_done <= 1'b0;
            tile_cnt   <= '0;
            {conf_mode, conf_idx_cnt, conf_trip_cnt, conf_is_new, conf_pad_u,
             conf_pad_l, conf_lim_r, conf_lim_d, conf_row_cnt} <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            desc_ready <= (w_count_nxt != C_FULL);
            busy       <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            agu_start  <= (w_state_nxt == S_START);
            tile_done  <= w_fin;
            layer_done <= w_fin && r_last;

            if (abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end

            // Done is sampled as a level, so stale done from the previous tile
            // is discarded by clearing in START before accumulation begins.
            if (abort || (r_state == S_START)) begin
                r_mask <= '0;
            end else if (r_state == S_WAIT) begin
                r_mask <= r_mask | agu_done;
            end

            if (abort) begin
                tile_cnt <= '0;
            end else if (w_fin) begin
                if (r_last) begin
                    tile_cnt <= '0;
                end else if (tile_cnt != '1) begin
                    tile_cnt <= tile_cnt + CNT_W'(1);
                end
            end

            if (w_pop) begin
                {r_last, conf_mode, conf_idx_cnt, conf_trip_cnt, conf_is_new, conf_pad_u,
                 conf_pad_l, conf_lim_r, conf_lim_d, conf_row_cnt} <= r_mem[r_rd_ptr];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_agu_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_agu_sched
// Brief   : Scoreboard bench for conv_agu_sched with directed tile scenarios.
// Rev     : 1.0  initial release
// ============================================================================
module tb_conv_agu_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [39:0] desc_data = '0;
    logic        abort = 1'b0;
    logic        agu_start;
    logic [3:0]  agu_done = '0;
    logic [1:0]  conf_mode;
    logic [7:0]  conf_idx_cnt;
    logic [7:0]  conf_trip_cnt;
    logic        conf_is_new;
    logic        conf_pad_u;
    logic        conf_pad_l;
    logic [5:0]  conf_lim_r;
    logic [5:0]  conf_lim_d;
    logic [5:0]  conf_row_cnt;
    logic        busy;
    logic        tile_done;
    logic        layer_done;
    logic [15:0] tile_cnt;

    conv_agu_sched #(.GRP_NUM(4), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_data(desc_data), .abort(abort), .agu_start(agu_start), .agu_done(agu_done),
        .conf_mode(conf_mode), .conf_idx_cnt(conf_idx_cnt), .conf_trip_cnt(conf_trip_cnt),
        .conf_is_new(conf_is_new), .conf_pad_u(conf_pad_u), .conf_pad_l(conf_pad_l),
        .conf_lim_r(conf_lim_r), .conf_lim_d(conf_lim_d), .conf_row_cnt(conf_row_cnt),
        .busy(busy), .tile_done(tile_done), .layer_done(layer_done), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          kind;   // 0: start pulse, 1: tile completion
        int          cyc;
        logic [5:0]  row;
        logic [7:0]  trip;
        logic        ld;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic exp_start(input int c, input logic [5:0] row, input logic [7:0] trip);
        exp_t e;
        e.kind = 1'b0; e.cyc = c; e.row = row; e.trip = trip; e.ld = 1'b0; e.cnt = '0;
        sb.push_back(e);
    endtask

    task automatic exp_tile(input int c, input logic ld, input logic [15:0] cnt);
        exp_t e;
        e.kind = 1'b1; e.cyc = c; e.row = '0; e.trip = '0; e.ld = ld; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic sb_check(input bit kind);
        exp_t e;
        bit   ok;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: kind=%0d seen at cyc %0d, nothing expected", kind, cyc);
            return;
        end
        e = sb.pop_front();
        if (kind == 1'b0)
            ok = (e.kind == 1'b0) && (e.cyc == cyc) && (conf_row_cnt == e.row) && (conf_trip_cnt == e.trip);
        else
            ok = (e.kind == 1'b1) && (e.cyc == cyc) && tile_done && (layer_done == e.ld) && (tile_cnt == e.cnt);
        if (ok) n_pass++;
        else $display("FAIL sb_event: got kind=%0d cyc=%0d row=%0d trip=%0d td=%0d ld=%0d cnt=%0d, expected kind=%0d cyc=%0d row=%0d trip=%0d ld=%0d cnt=%0d",
                      kind, cyc, conf_row_cnt, conf_trip_cnt, tile_done, layer_done, tile_cnt,
                      e.kind, e.cyc, e.row, e.trip, e.ld, e.cnt);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (agu_start) sb_check(1'b0);
            if (tile_done || layer_done) sb_check(1'b1);
        end
    end

    function automatic logic [39:0] mk(input logic last, input logic [7:0] trip, input logic [5:0] row);
        return {last, 2'b01, 8'h11, trip, 3'b100, 6'd5, 6'd9, row};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push(input logic [39:0] d);
        chk("push_ready", desc_ready, 1);
        desc_valid = 1'b1;
        desc_data  = d;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic done_at(input int t, input logic [3:0] m);
        go_to(t);
        agu_done = m;
        tick();
        agu_done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int s;
        tick(); tick();
        chk("rst_ready", desc_ready, 1);
        chk("rst_start", agu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_tile_cnt", tile_cnt, 0);
        chk("rst_conf_row", conf_row_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Single tile, last=1: start two cycles after acceptance, completion one after done.
        c = cyc;
        exp_start(c + 2, 6'd3, 8'd2);
        exp_tile(c + 11, 1'b1, 16'd0);
        push(mk(1'b1, 8'd2, 6'd3));
        go_to(c + 2);
        chk("t1_busy", busy, 1);
        done_at(c + 10, 4'hF);
        go_to(c + 13);
        chk("t1_idle_busy", busy, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Staggered done; done during the START cycle alone must not count.
        c = cyc;
        s = c + 2;
        exp_start(s, 6'd7, 8'd4);
        exp_tile(s + 13, 1'b1, 16'd0);
        push(mk(1'b1, 8'd4, 6'd7));
        done_at(s, 4'hF);
        done_at(s + 3, 4'b0001);
        done_at(s + 7, 4'b0110);
        done_at(s + 12, 4'b1000);
        go_to(s + 15);
        chk("t3_sb_empty", sb.size(), 0);

        // Three tiles of a layer: counts 1, 2, then cleared with layer_done.
        c = cyc;
        exp_start(c + 2, 6'd1, 8'd8);
        exp_tile(c + 5, 1'b0, 16'd1);
        exp_start(c + 6, 6'd2, 8'd8);
        exp_tile(c + 10, 1'b0, 16'd2);
        exp_start(c + 11, 6'd3, 8'd8);
        exp_tile(c + 13, 1'b1, 16'd0);
        push(mk(1'b0, 8'd8, 6'd1));
        push(mk(1'b0, 8'd8, 6'd2));
        push(mk(1'b1, 8'd8, 6'd3));
        done_at(c + 4, 4'hF);
        done_at(c + 9, 4'hF);
        done_at(c + 12, 4'hF);
        go_to(c + 15);
        chk("t4_sb_empty", sb.size(), 0);

        // FIFO fill: one tile in flight plus four queued, sixth descriptor stalls.
        c = cyc;
        exp_start(c + 2, 6'd10, 8'd1);
        exp_tile(c + 7, 1'b0, 16'd1);
        for (int k = 0; k < 5; k++) begin
            exp_start(c + 8 + 3 * k, 6'(11 + k), 8'd1);
            exp_tile(c + 10 + 3 * k, (k == 4) ? 1'b1 : 1'b0, (k == 4) ? 16'd0 : 16'(k + 2));
        end
        for (int k = 0; k < 5; k++) push(mk(1'b0, 8'd1, 6'(10 + k)));
        chk("t2_full_ready", desc_ready, 0);
        chk("t2_full_busy", busy, 1);
        desc_valid = 1'b1;
        desc_data  = mk(1'b1, 8'd1, 6'd15);
        done_at(c + 6, 4'hF);
        chk("t2_stall_ready", desc_ready, 0);
        tick();
        chk("t2_freed_ready", desc_ready, 1);
        tick();
        desc_valid = 1'b0;
        chk("t2_refull_ready", desc_ready, 0);
        for (int k = 0; k < 5; k++) done_at(c + 9 + 3 * k, 4'hF);
        go_to(c + 25);
        chk("t2_sb_empty", sb.size(), 0);

        // Abort in WAIT with two queued descriptors and a coincident push.
        c = cyc;
        exp_start(c + 2, 6'd20, 8'd3);
        exp_tile(c + 4, 1'b0, 16'd1);
        exp_start(c + 5, 6'd21, 8'd3);
        push(mk(1'b0, 8'd3, 6'd20));
        push(mk(1'b0, 8'd3, 6'd21));
        push(mk(1'b0, 8'd3, 6'd22));
        agu_done = 4'hF;
        push(mk(1'b0, 8'd3, 6'd23));
        agu_done = '0;
        go_to(c + 7);
        abort      = 1'b1;
        desc_valid = 1'b1;
        desc_data  = mk(1'b0, 8'd3, 6'd30);
        tick();
        abort      = 1'b0;
        desc_valid = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_ready", desc_ready, 1);
        chk("t5_tile_cnt", tile_cnt, 0);
        chk("t5_conf_hold", conf_row_cnt, 21);
        done_at(c + 9, 4'hF);
        go_to(c + 18);
        chk("t5_busy_late", busy, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // Asynchronous reset in WAIT, then a normal tile after release.
        c = cyc;
        exp_start(c + 2, 6'd40, 8'd6);
        exp_tile(c + 4, 1'b0, 16'd1);
        exp_start(c + 5, 6'd41, 8'd6);
        push(mk(1'b0, 8'd6, 6'd40));
        push(mk(1'b0, 8'd6, 6'd41));
        done_at(c + 3, 4'hF);
        go_to(c + 7);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", desc_ready, 1);
        chk("t6_rst_start", agu_start, 0);
        chk("t6_rst_tile_cnt", tile_cnt, 0);
        chk("t6_rst_conf_row", conf_row_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        c = cyc;
        exp_start(c + 2, 6'd42, 8'd6);
        exp_tile(c + 4, 1'b1, 16'd0);
        push(mk(1'b1, 8'd6, 6'd42));
        done_at(c + 3, 4'hF);
        go_to(c + 6);
        chk("t6_busy_end", busy, 0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
